// File: rtl/scan_sequencer.sv
// scan_sequencer: walks enabled channels of an 8-bit mask in ascending order, holding each for dwell+1 cycles
//   clk, rst        : clock, synchronous active-high reset
//   start, stop     : begin a sweep from IDLE / abort from any state (stop wins)
//   loop            : restart the sweep at its end instead of returning to IDLE
//   en_mask, dwell  : channel enables and per-channel hold (cycles minus 1), latched at start
//   sel, sel_valid  : current channel index and its qualifier
//   busy            : sweep in progress
//   sweep_done      : one-cycle pulse at normal sweep end
//   start_err       : one-cycle pulse for a start with an empty mask
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [7:0]         en_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               sweep_done,
    output logic               start_err
);
    typedef enum logic [1:0] {IDLE, SEEK, DWELL} state_t;
    state_t             state_q;
    logic [7:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [3:0]         ptr_q;
    logic [2:0]         sel_q;
    logic               sel_valid_q;
    logic               busy_q;
    logic               sweep_done_q;
    logic               start_err_q;
    logic               found;
    logic [2:0]         idx;
    // descending scan so the lowest enabled channel at or above ptr wins
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && 4'(i) >= ptr_q) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            sel_q        <= '0;
            sel_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            start_err_q  <= 1'b0;
            if (stop) begin
                state_q     <= IDLE;
                sel_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && |en_mask) begin
                            mask_q  <= en_mask;
                            dwell_q <= dwell;
                            ptr_q   <= 4'd0;
                            busy_q  <= 1'b1;
                            state_q <= SEEK;
                        end else if (start) begin
                            start_err_q <= 1'b1;
                        end
                    end
                    SEEK: begin
                        if (found) begin
                            sel_q       <= idx;
                            sel_valid_q <= 1'b1;
                            cnt_q       <= dwell_q;
                            state_q     <= DWELL;
                        end else begin
                            sweep_done_q <= 1'b1;
                            if (loop) begin
                                ptr_q <= 4'd0;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end
                    DWELL: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            sel_valid_q <= 1'b0;
                            // 4-bit add so channel 7 advances to the past-the-end value 8
                            ptr_q       <= {1'b0, sel_q} + 4'd1;
                            state_q     <= SEEK;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;
    assign start_err  = start_err_q;
endmodule
